fb_write_sched: RTL and testbench
=================================

Name: fb_write_sched

Overview:
- Owns the single write port of the dual-port framebuffer RAM that the VGA output reads.
- Arbitrates between two sources:
  - the Model 4 capture pixel stream (address, pixel, valid);
  - an internal clear engine that zero-fills the buffer.
- Schedules a clear on reset, on 64/80-column mode change, or on explicit request.
- After a clear, holds off capture until the next frame boundary so no partial frame is written.

Parameters:
- FB_DEPTH, 192000, number of framebuffer locations; valid addresses are 0..FB_DEPTH-1.
- ADDR_W, 18, write address width.
- DROP_W, 16, width of the dropped-write counter.

Ports:
- dotclk  in  1  Sole clock; all logic on posedge.
- reset  in  1  Synchronous, active-high reset.
- cap_valid  in  1  Capture requests a write this cycle.
- cap_addr  in  ADDR_W  Capture write address.
- cap_pixel  in  1  Capture pixel value.
- mode_80col  in  1  Current column mode from capture: 1 = 80-column, 0 = 64-column. Already synchronised to dotclk.
- vsync_n  in  1  Active-low vsync, already double-flopped to dotclk.
- clear_req  in  1  One-cycle pulse requesting a full clear.
- waddr  out  ADDR_W  RAM write address.
- wdata  out  1  RAM write data.
- wren  out  1  RAM write enable.
- clearing  out  1  High while in CLEAR.
- clear_done  out  1  One-cycle pulse when a clear completes.
- drop_count  out  DROP_W  Saturating count of discarded capture writes.

Behaviour:
- States: CLEAR, WAIT_FRAME, PASS. Reset forces CLEAR and takes priority over everything else, including an in-progress clear.
- Reset values:
  - waddr = 0, wdata = 0, wren = 0;
  - clearing = 1 (state is CLEAR);
  - clear_done = 0, drop_count = 0;
  - clear counter = 0; mode_q = mode_80col; vs_seen = 0.
- All RAM outputs are registered; one cycle of latency from request to waddr/wdata/wren.

CLEAR:
- Each cycle drive wren = 1, wdata = 0, waddr = ctr, then ctr++.
- On the cycle that writes ctr = FB_DEPTH-1:
  - pulse clear_done on the following cycle;
  - go to WAIT_FRAME with vs_seen = 0.
- A full clear is exactly FB_DEPTH write cycles.
- A mode change or clear_req during CLEAR restarts ctr at 0; no clear_done is issued for the aborted pass.

WAIT_FRAME:
- wren = 0.
- Set vs_seen when vsync_n = 0.
- Go to PASS on the first cycle where vs_seen = 1 and vsync_n = 1 (rising edge out of vsync).
- A mode change or clear_req here goes back to CLEAR with ctr = 0.

PASS:
- If cap_valid and cap_addr < FB_DEPTH, next cycle drive wren = 1, waddr = cap_addr, wdata = cap_pixel.
- Otherwise wren = 0.
- When cap_valid is high with cap_addr >= FB_DEPTH, the write is dropped and drop_count increments.

Mode change detection:
- mode_q registers mode_80col every cycle.
- mode_80col != mode_q while in PASS is a mode change: go to CLEAR with ctr = 0.
- The capture write presented on that same cycle is dropped and counted.
- clear_req in PASS behaves the same way.

Dropped writes:
- cap_valid while in CLEAR or WAIT_FRAME increments drop_count.
- drop_count saturates at 2^DROP_W-1 and is cleared only by reset.

Simultaneous events:
- Mode change and clear_req in the same cycle cause a single restart.
- A clear_req on the final clear cycle restarts the clear, and clear_done is suppressed.

Other rules:
- wren is never high with waddr >= FB_DEPTH.
- The clear counter is ADDR_W bits wide and never reaches FB_DEPTH in any cycle where it drives waddr.

Test Plan:
1. Release reset -> exactly 192000 consecutive cycles with wren = 1, wdata = 0, waddr running 0..191999, then clear_done for 1 cycle and clearing = 0.
2. After clear, hold vsync_n = 1 and drive cap_valid pulses -> wren stays 0 and drop_count increments per pulse. Then vsync_n 1→0→1 -> PASS; cap_valid with addr = 1234, pixel = 1 -> next cycle wren = 1, waddr = 1234, wdata = 1.
3. In PASS, toggle mode_80col 0→1 with cap_valid = 1 -> that write is dropped (drop_count +1), clearing rises next cycle and a full 192000-cycle clear runs.
4. Mid-clear at ctr = 50000, pulse clear_req -> waddr returns to 0, no clear_done until 192000 uninterrupted writes complete.
5. In PASS, cap_valid with cap_addr = 192000 and then 262143 -> no wren, drop_count +2. Force drop_count to 65535 -> a further drop keeps it at 65535.
6. Assert reset at ctr = 100 of a clear and again in PASS mid-write -> next cycle wren = 0, waddr = 0, drop_count = 0, clear restarts from address 0.

Source files
------------

// File: rtl/fb_write_sched.sv
// Write-port scheduler for the VGA framebuffer: arbitrates the capture pixel stream
// against a zero-fill clear engine, and gates capture to whole frames after each clear.
module fb_write_sched #(
    parameter int FB_DEPTH = 192000,
    parameter int ADDR_W   = 18,
    parameter int DROP_W   = 16
) (
    input  logic              dotclk,
    input  logic              reset,
    input  logic              cap_valid,
    input  logic [ADDR_W-1:0] cap_addr,
    input  logic              cap_pixel,
    input  logic              mode_80col,
    input  logic              vsync_n,
    input  logic              clear_req,
    output logic [ADDR_W-1:0] waddr,
    output logic              wdata,
    output logic              wren,
    output logic              clearing,
    output logic              clear_done,
    output logic [DROP_W-1:0] drop_count
);

    // state      | meaning
    // S_CLEAR    | zero-filling every location, one write per cycle
    // S_WAIT     | clear finished, waiting for the end of a vsync pulse
    // S_PASS     | forwarding in-range capture writes to the RAM
    typedef enum logic [1:0] {S_CLEAR, S_WAIT, S_PASS} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);
    localparam logic [ADDR_W:0]   CAP_LIMIT = (ADDR_W + 1)'(FB_DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ctr_q, ctr_d;
    logic              mode_q;
    logic              vs_seen_q, vs_seen_d;
    logic              done_pend_q;
    logic              restart, cap_ok;
    logic              wren_d, wdata_d, done_set, drop_inc;
    logic [ADDR_W-1:0] waddr_d;

    // A mode change and a clear request collapse into one restart.
    assign restart  = (mode_80col != mode_q) || clear_req;
    assign cap_ok   = cap_valid && ({1'b0, cap_addr} < CAP_LIMIT);
    assign clearing = (state_q == S_CLEAR);

    always_comb begin
        state_d   = state_q;
        ctr_d     = ctr_q;
        vs_seen_d = vs_seen_q;
        wren_d    = 1'b0;
        waddr_d   = waddr;
        wdata_d   = wdata;
        done_set  = 1'b0;
        drop_inc  = 1'b0;
        case (state_q)
            S_CLEAR: begin
                wren_d   = 1'b1;
                waddr_d  = ctr_q;
                wdata_d  = 1'b0;
                drop_inc = cap_valid;
                if (restart) begin
                    ctr_d = '0;
                end else if (ctr_q == LAST_ADDR) begin
                    state_d   = S_WAIT;
                    ctr_d     = '0;
                    vs_seen_d = 1'b0;
                    done_set  = 1'b1;
                end else begin
                    ctr_d = ctr_q + 1'b1;
                end
            end
            S_WAIT: begin
                drop_inc = cap_valid;
                if (restart) begin
                    state_d   = S_CLEAR;
                    ctr_d     = '0;
                    vs_seen_d = 1'b0;
                end else if (!vsync_n) begin
                    vs_seen_d = 1'b1;
                end else if (vs_seen_q) begin
                    state_d = S_PASS;
                end
            end
            S_PASS: begin
                if (restart) begin
                    state_d   = S_CLEAR;
                    ctr_d     = '0;
                    vs_seen_d = 1'b0;
                    drop_inc  = cap_valid;
                end else if (cap_ok) begin
                    wren_d  = 1'b1;
                    waddr_d = cap_addr;
                    wdata_d = cap_pixel;
                end else begin
                    drop_inc = cap_valid;
                end
            end
            default: begin
                state_d = S_CLEAR;
                ctr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge dotclk) begin
        if (reset) begin
            state_q     <= S_CLEAR;
            ctr_q       <= '0;
            mode_q      <= mode_80col;
            vs_seen_q   <= 1'b0;
            done_pend_q <= 1'b0;
            waddr       <= '0;
            wdata       <= 1'b0;
            wren        <= 1'b0;
            clear_done  <= 1'b0;
            drop_count  <= '0;
        end else begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            mode_q      <= mode_80col;
            vs_seen_q   <= vs_seen_d;
            // clear_done lands on the cycle after the last zero write is presented.
            done_pend_q <= done_set;
            clear_done  <= done_pend_q;
            waddr       <= waddr_d;
            wdata       <= wdata_d;
            wren        <= wren_d;
            if (drop_inc && (drop_count != '1))
                drop_count <= drop_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fb_write_sched.sv
// Bench for fb_write_sched with a shrunken framebuffer so full clears stay short;
// table-driven PASS vectors go through a scoreboard queue, clears are walked cycle by cycle.
module tb_fb_write_sched;
    localparam int D    = 300;
    localparam int AW   = 18;
    localparam int DW   = 6;
    localparam int DMAX = 63;

    logic          dotclk = 1'b0;
    logic          reset, cap_valid, cap_pixel, mode_80col, vsync_n, clear_req;
    logic [AW-1:0] cap_addr;
    logic [AW-1:0] waddr;
    logic          wdata, wren, clearing, clear_done;
    logic [DW-1:0] drop_count;

    fb_write_sched #(.FB_DEPTH(D), .ADDR_W(AW), .DROP_W(DW)) dut (
        .dotclk(dotclk), .reset(reset), .cap_valid(cap_valid), .cap_addr(cap_addr),
        .cap_pixel(cap_pixel), .mode_80col(mode_80col), .vsync_n(vsync_n),
        .clear_req(clear_req), .waddr(waddr), .wdata(wdata), .wren(wren),
        .clearing(clearing), .clear_done(clear_done), .drop_count(drop_count)
    );

    always #5 dotclk = ~dotclk;

    typedef struct {
        logic          cv;
        logic [AW-1:0] addr;
        logic          pix;
    } vec_t;

    typedef struct {
        logic          wren;
        logic [AW-1:0] waddr;
        logic          wdata;
        int            drop;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_drop = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, wanted %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge dotclk);
        #1;
    endtask

    task automatic bump_drop();
        if (exp_drop < DMAX) exp_drop++;
    endtask

    task automatic expect_clear(input int start);
        int bad = 0;
        for (int i = start; i < D; i++) begin
            tick();
            if (!(wren === 1'b1 && wdata === 1'b0 && waddr == AW'(i) && clear_done === 1'b0))
                bad++;
        end
        chk("clear_writes_bad", bad, 0);
        tick();
        chk("clear_done_pulse", int'(clear_done), 1);
        chk("clear_wren_off", int'(wren), 0);
        chk("clearing_low", int'(clearing), 0);
        tick();
        chk("clear_done_single", int'(clear_done), 0);
    endtask

    task automatic goto_pass();
        vsync_n = 1'b0;
        tick();
        vsync_n = 1'b1;
        tick();
    endtask

    initial begin
        exp_t e, got;
        int   bad;

        vecs[0] = '{cv: 1'b1, addr: AW'(1234 % D), pix: 1'b1};
        vecs[1] = '{cv: 1'b1, addr: AW'(0),        pix: 1'b0};
        vecs[2] = '{cv: 1'b1, addr: AW'(D - 1),    pix: 1'b1};
        vecs[3] = '{cv: 1'b1, addr: AW'(D),        pix: 1'b1};
        vecs[4] = '{cv: 1'b1, addr: AW'(262143),   pix: 1'b0};
        vecs[5] = '{cv: 1'b0, addr: AW'(5),        pix: 1'b1};
        vecs[6] = '{cv: 1'b1, addr: AW'(192000),   pix: 1'b1};
        vecs[7] = '{cv: 1'b1, addr: AW'(7),        pix: 1'b1};

        reset = 1'b1; cap_valid = 1'b0; cap_addr = '0; cap_pixel = 1'b0;
        mode_80col = 1'b0; vsync_n = 1'b1; clear_req = 1'b0;
        tick();
        tick();
        chk("rst_wren", int'(wren), 0);
        chk("rst_waddr", int'(waddr), 0);
        chk("rst_wdata", int'(wdata), 0);
        chk("rst_clearing", int'(clearing), 1);
        chk("rst_clear_done", int'(clear_done), 0);
        chk("rst_drop", int'(drop_count), 0);

        reset = 1'b0;
        expect_clear(0);

        // Capture attempts while waiting for a frame boundary are dropped.
        for (int k = 0; k < 3; k++) begin
            cap_valid = 1'b1; cap_addr = AW'(12);
            tick();
            bump_drop();
            chk("wait_drop_cnt", int'(drop_count), exp_drop);
            chk("wait_wren", int'(wren), 0);
            cap_valid = 1'b0;
            tick();
        end
        goto_pass();

        for (int i = 0; i < 8; i++) begin
            cap_valid = vecs[i].cv; cap_addr = vecs[i].addr; cap_pixel = vecs[i].pix;
            e.wren = vecs[i].cv && (int'(vecs[i].addr) < D);
            e.waddr = vecs[i].addr;
            e.wdata = vecs[i].pix;
            if (vecs[i].cv && !e.wren) bump_drop();
            e.drop = exp_drop;
            sb.push_back(e);
            tick();
            got = sb.pop_front();
            chk("vec_wren", int'(wren), int'(got.wren));
            if (got.wren) begin
                chk("vec_waddr", int'(waddr), int'(got.waddr));
                chk("vec_wdata", int'(wdata), int'(got.wdata));
            end
            chk("vec_drop", int'(drop_count), got.drop);
        end
        cap_valid = 1'b0;

        // Mode change in PASS: concurrent write dropped, full clear follows.
        mode_80col = 1'b1; cap_valid = 1'b1; cap_addr = AW'(10);
        tick();
        bump_drop();
        chk("mode_drop", int'(drop_count), exp_drop);
        chk("mode_wren", int'(wren), 0);
        chk("mode_clearing", int'(clearing), 1);
        cap_valid = 1'b0;
        expect_clear(0);

        // clear_req from WAIT, then again mid-clear.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("req_clearing", int'(clearing), 1);
        bad = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (!(wren === 1'b1 && waddr == AW'(i) && clear_done === 1'b0)) bad++;
        end
        chk("mid_prefix_bad", bad, 0);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("mid_abort_addr", int'(waddr), 150);
        expect_clear(0);

        // clear_req on the final clear cycle suppresses clear_done.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < D - 1; i++) tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("final_abort_addr", int'(waddr), D - 1);
        tick();
        chk("final_abort_no_done", int'(clear_done), 0);
        chk("final_abort_wren", int'(wren), 1);
        chk("final_abort_restart", int'(waddr), 0);
        expect_clear(1);

        // Mode change together with clear_req: one restart.
        mode_80col = 1'b0; clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("both_clearing", int'(clearing), 1);
        expect_clear(0);
        goto_pass();

        // Out-of-range addresses and saturation.
        cap_valid = 1'b1; cap_addr = AW'(D);
        tick();
        bump_drop();
        chk("oor_depth_wren", int'(wren), 0);
        chk("oor_depth_drop", int'(drop_count), exp_drop);
        cap_addr = AW'(262143);
        tick();
        bump_drop();
        chk("oor_max_wren", int'(wren), 0);
        chk("oor_max_drop", int'(drop_count), exp_drop);
        cap_addr = AW'(D);
        for (int i = 0; i < 70; i++) begin
            tick();
            bump_drop();
        end
        chk("sat_value", int'(drop_count), DMAX);
        tick();
        chk("sat_hold", int'(drop_count), DMAX);
        chk("sat_wren", int'(wren), 0);
        cap_addr = AW'(20); cap_pixel = 1'b1;
        tick();
        chk("post_sat_wren", int'(wren), 1);
        chk("post_sat_waddr", int'(waddr), 20);
        cap_valid = 1'b0;

        // Reset mid-clear.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        reset = 1'b1;
        tick();
        exp_drop = 0;
        chk("rst_clr_wren", int'(wren), 0);
        chk("rst_clr_waddr", int'(waddr), 0);
        chk("rst_clr_drop", int'(drop_count), 0);
        chk("rst_clr_clearing", int'(clearing), 1);
        reset = 1'b0;
        expect_clear(0);
        goto_pass();

        // Reset in PASS while a write is in flight.
        cap_valid = 1'b1; cap_addr = AW'(33); cap_pixel = 1'b1;
        tick();
        chk("pass_write_wren", int'(wren), 1);
        chk("pass_write_waddr", int'(waddr), 33);
        cap_addr = AW'(44); reset = 1'b1;
        tick();
        chk("rst_pass_wren", int'(wren), 0);
        chk("rst_pass_waddr", int'(waddr), 0);
        chk("rst_pass_drop", int'(drop_count), 0);
        cap_valid = 1'b0; reset = 1'b0;
        expect_clear(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
